// File: rtl/active_list_flush_unit.sv
// Branch-mispredict rollback: walks the active list youngest-first,
// restoring the rename map and freeing physical registers, then truncates the tail.
module active_list_flush_unit #(
    parameter int AL_DEPTH = 32,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 6,
    localparam int AL_IDX_W = $clog2(AL_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mispredict_valid,
    input  logic [AL_IDX_W-1:0] mispredict_tag,
    input  logic [AL_IDX_W-1:0] al_head,
    input  logic [AL_IDX_W-1:0] al_tail,
    output logic [AL_IDX_W-1:0] al_rd_idx,
    input  logic                al_rd_has_dest,
    input  logic [AREG_W-1:0]   al_rd_areg,
    input  logic [PREG_W-1:0]   al_rd_old_preg,
    input  logic [PREG_W-1:0]   al_rd_new_preg,
    output logic                map_restore_we,
    output logic [AREG_W-1:0]   map_restore_areg,
    output logic [PREG_W-1:0]   map_restore_preg,
    output logic                free_push_valid,
    output logic [PREG_W-1:0]   free_push_preg,
    output logic                al_tail_we,
    output logic [AL_IDX_W-1:0] al_tail_new,
    output logic                flush_in_progress,
    output logic                flush_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AL_IDX_W-1:0]   cursor_q, cursor_d;
    logic [AL_IDX_W-1:0]   stop_q, stop_d;

    logic [AL_IDX_W-1:0]   tag_p1;
    logic [AL_IDX_W-1:0]   stop_m1;
    logic [AL_IDX_W-1:0]   age_tag;
    logic [AL_IDX_W-1:0]   age_lim;
    logic                  extend;

    // A later mispredict only matters if it is older than everything already squashed.
    always_comb begin
        tag_p1  = mispredict_tag + AL_IDX_W'(1);
        stop_m1 = stop_q - AL_IDX_W'(1);
        age_tag = mispredict_tag - al_head;
        age_lim = stop_m1 - al_head;
        extend  = mispredict_valid && (age_tag < age_lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            stop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        stop_d   = stop_q;
        case (state_q)
            IDLE: begin
                if (mispredict_valid) begin
                    stop_d   = tag_p1;
                    cursor_d = al_tail - AL_IDX_W'(1);
                    state_d  = (al_tail == tag_p1) ? DONE : WALK;
                end
            end
            WALK: begin
                if (extend) begin
                    stop_d = tag_p1;
                end
                if (cursor_q == stop_q && !extend) begin
                    state_d = DONE;
                end else begin
                    cursor_d = cursor_q - AL_IDX_W'(1);
                end
            end
            DONE: begin
                if (extend) begin
                    cursor_d = stop_m1;
                    stop_d   = tag_p1;
                    state_d  = WALK;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        al_rd_idx         = cursor_q;
        map_restore_we    = 1'b0;
        map_restore_areg  = '0;
        map_restore_preg  = '0;
        free_push_valid   = 1'b0;
        free_push_preg    = '0;
        al_tail_we        = 1'b0;
        al_tail_new       = '0;
        flush_done        = 1'b0;
        flush_in_progress = (state_q != IDLE);
        if (state_q == WALK && al_rd_has_dest) begin
            map_restore_we   = 1'b1;
            map_restore_areg = al_rd_areg;
            map_restore_preg = al_rd_old_preg;
            free_push_valid  = 1'b1;
            free_push_preg   = al_rd_new_preg;
        end
        if (state_q == DONE && !extend) begin
            al_tail_we  = 1'b1;
            al_tail_new = stop_q;
            flush_done  = 1'b1;
        end
    end

endmodule

// File: tb/tb_active_list_flush_unit.sv
// Randomized bench for active_list_flush_unit against a queue-based rollback model.
module tb_active_list_flush_unit;

    localparam int D = 32;
    localparam int M = D - 1;
    localparam int IW = 5;

    logic          clk;
    logic          rst_n;
    logic          mispredict_valid;
    logic [IW-1:0] mispredict_tag;
    logic [IW-1:0] al_head;
    logic [IW-1:0] al_tail;
    logic [IW-1:0] al_rd_idx;
    logic          al_rd_has_dest;
    logic [4:0]    al_rd_areg;
    logic [5:0]    al_rd_old_preg;
    logic [5:0]    al_rd_new_preg;
    logic          map_restore_we;
    logic [4:0]    map_restore_areg;
    logic [5:0]    map_restore_preg;
    logic          free_push_valid;
    logic [5:0]    free_push_preg;
    logic          al_tail_we;
    logic [IW-1:0] al_tail_new;
    logic          flush_in_progress;
    logic          flush_done;

    logic       mem_hd   [D];
    logic [4:0] mem_areg [D];
    logic [5:0] mem_old  [D];
    logic [5:0] mem_new  [D];

    int n_total = 0;
    int n_pass  = 0;

    // model state: entries still to roll back (youngest first) and the final tail
    int q[$];
    bit active = 0;
    int target = 0;

    int rlog[$];
    int tlog[$];
    int ip_cnt = 0;
    int dn_cnt = 0;

    active_list_flush_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mispredict_valid  (mispredict_valid),
        .mispredict_tag    (mispredict_tag),
        .al_head           (al_head),
        .al_tail           (al_tail),
        .al_rd_idx         (al_rd_idx),
        .al_rd_has_dest    (al_rd_has_dest),
        .al_rd_areg        (al_rd_areg),
        .al_rd_old_preg    (al_rd_old_preg),
        .al_rd_new_preg    (al_rd_new_preg),
        .map_restore_we    (map_restore_we),
        .map_restore_areg  (map_restore_areg),
        .map_restore_preg  (map_restore_preg),
        .free_push_valid   (free_push_valid),
        .free_push_preg    (free_push_preg),
        .al_tail_we        (al_tail_we),
        .al_tail_new       (al_tail_new),
        .flush_in_progress (flush_in_progress),
        .flush_done        (flush_done)
    );

    assign al_rd_has_dest = mem_hd[al_rd_idx];
    assign al_rd_areg     = mem_areg[al_rd_idx];
    assign al_rd_old_preg = mem_old[al_rd_idx];
    assign al_rd_new_preg = mem_new[al_rd_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic bit older(input int t, input int lim, input int h);
        return ((t - h) & M) < ((lim - h) & M);
    endfunction

    task automatic enqueue(input int from, input int cnt);
        for (int i = 0; i < cnt; i++) q.push_back((from - i) & M);
    endtask

    // single compare process: expected outputs from the model, then advance it
    always @(negedge clk) begin
        int idx;
        bit ext;
        bit etw;
        bit was;
        if (!rst_n) begin
            chk("rst_inprog", flush_in_progress, 0);
            chk("rst_restore", map_restore_we, 0);
            chk("rst_push", free_push_valid, 0);
            chk("rst_tail_we", al_tail_we, 0);
            chk("rst_done", flush_done, 0);
            chk("rst_rd_idx", al_rd_idx, 0);
            q.delete();
            active = 0;
        end else begin
            was = active;
            ext = 0;
            chk("inprog", flush_in_progress, active);
            if (active && q.size() > 0) begin
                idx = q[0];
                chk("rd_idx", al_rd_idx, idx);
                chk("restore_we", map_restore_we, mem_hd[idx]);
                chk("restore_areg", map_restore_areg, mem_hd[idx] ? mem_areg[idx] : 0);
                chk("restore_preg", map_restore_preg, mem_hd[idx] ? mem_old[idx] : 0);
                chk("push_valid", free_push_valid, mem_hd[idx]);
                chk("push_preg", free_push_preg, mem_hd[idx] ? mem_new[idx] : 0);
            end else begin
                chk("restore_we_idle", map_restore_we, 0);
                chk("push_valid_idle", free_push_valid, 0);
            end
            if (active && q.size() == 0)
                ext = mispredict_valid && older(mispredict_tag, target - 1, al_head);
            etw = active && q.size() == 0 && !ext;
            chk("tail_we", al_tail_we, etw);
            chk("tail_new", al_tail_new, etw ? target : 0);
            chk("flush_done", flush_done, etw);
            if (map_restore_we) rlog.push_back(al_rd_idx);
            if (al_tail_we) tlog.push_back(al_tail_new);
            if (flush_in_progress) ip_cnt++;
            if (flush_done) dn_cnt++;
            if (active && q.size() > 0) void'(q.pop_front());
            else if (etw) active = 0;
            if (mispredict_valid) begin
                if (!was) begin
                    active = 1;
                    target = (mispredict_tag + 1) & M;
                    enqueue(al_tail - 1, (al_tail - mispredict_tag - 1) & M);
                end else if (older(mispredict_tag, target - 1, al_head)) begin
                    enqueue(target - 1, (target - mispredict_tag - 1) & M);
                    target = (mispredict_tag + 1) & M;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < D; i++) begin
            mem_hd[i]   = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            mem_areg[i] = 5'($urandom);
            mem_old[i]  = 6'($urandom);
            mem_new[i]  = 6'($urandom);
        end
    endtask

    // one flush; xat>0 injects tag xtag on that walk cycle; rl>0 injects random live tags
    task automatic flush(input int h, input int t, input int tg,
                         input int xat, input int xtag, input int rl);
        rlog.delete();
        tlog.delete();
        ip_cnt = 0;
        dn_cnt = 0;
        al_head = IW'(h);
        al_tail = IW'(t);
        mispredict_tag = IW'(tg);
        mispredict_valid = 1'b1;
        cyc();
        mispredict_valid = 1'b0;
        for (int c = 1; c < 200 && flush_in_progress; c++) begin
            if (c == xat) begin
                mispredict_valid = 1'b1;
                mispredict_tag = IW'(xtag);
            end else if (rl > 0 && $urandom_range(0, 4) == 0) begin
                mispredict_valid = 1'b1;
                mispredict_tag = IW'(h + $urandom_range(0, rl - 1));
            end
            cyc();
            mispredict_valid = 1'b0;
        end
        if (flush_in_progress) chk("flush_timeout", 1, 0);
    endtask

    task automatic chk_log(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        mispredict_valid = 1'b0;
        mispredict_tag = '0;
        al_head = '0;
        al_tail = '0;
        fill_mem(0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inprog", flush_in_progress, 0);
        chk("reset_idx", al_rd_idx, 0);
        rst_n = 1'b1;
        cyc();

        flush(0, 8, 3, 0, 0, 0);
        chk_log("r031_walk", rlog, '{7, 6, 5, 4});
        chk_log("r031_tail", tlog, '{4});
        chk("r031_inprog", ip_cnt, 5);

        flush(0, 6, 5, 0, 0, 0);
        chk("r032_restores", rlog.size(), 0);
        chk_log("r032_tail", tlog, '{6});
        chk("r032_inprog", ip_cnt, 1);

        flush(28, 3, 30, 0, 0, 0);
        chk_log("r033_walk", rlog, '{2, 1, 0, 31});
        chk_log("r033_tail", tlog, '{31});

        flush(0, 12, 6, 2, 2, 0);
        chk_log("r034_walk", rlog, '{11, 10, 9, 8, 7, 6, 5, 4, 3});
        chk_log("r034_tail", tlog, '{3});
        chk("r034_done", dn_cnt, 1);

        mem_hd[9] = 1'b0;
        flush(0, 12, 6, 2, 9, 0);
        chk_log("r035_walk", rlog, '{11, 10, 8, 7});
        chk_log("r035_tail", tlog, '{7});
        chk("r035_inprog", ip_cnt, 6);
        mem_hd[9] = 1'b1;

        tlog.delete();
        dn_cnt = 0;
        al_head = '0;
        al_tail = IW'(12);
        mispredict_tag = IW'(3);
        mispredict_valid = 1'b1;
        cyc();
        mispredict_valid = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("r036_inprog", flush_in_progress, 0);
        chk("r036_restore", map_restore_we, 0);
        chk("r036_push", free_push_valid, 0);
        chk("r036_tail_we", al_tail_we, 0);
        chk("r036_idx", al_rd_idx, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("r036_idle", flush_in_progress, 0);
        chk("r036_no_tail", tlog.size(), 0);
        chk("r036_no_done", dn_cnt, 0);

        for (int s = 0; s < 300; s++) begin
            int h;
            int l;
            int k;
            fill_mem(1);
            h = $urandom_range(0, M);
            l = $urandom_range(1, M);
            k = $urandom_range(0, l - 1);
            flush(h, (h + l) & M, (h + k) & M, 0, 0, l);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
